tug_field: RTL

Parametrised tug-of-war playfield. It generalises the single-light cell into an N-light field with one registered light-position counter, win detection at both ends, per-player score counters and a match-over condition. It sits between the edge-detected player key pulses and the LED/HEX display drivers, and replaces the chain of per-light cells.

---
 rtl/tug_pkg.sv | 15 +
 rtl/tug_score.sv | 30 +++
 rtl/tug_field.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        LWIN = 2'd1,
        RWIN = 2'd2,
        OVER = 2'd3
    } tug_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

endpackage

// File: rtl/tug_score.sv
// Saturating round-score counter; holds at MAX_SCORE instead of wrapping.
module tug_score
    import tug_pkg::*;
#(
    parameter int PTS_W     = 3,
    parameter int MAX_SCORE = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [PTS_W-1:0] count,
    output logic             atMax
);

    localparam logic [PTS_W-1:0] MAX_V = PTS_W'(MAX_SCORE);

    logic [PTS_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign atMax = (r_count == MAX_V);

endmodule

// File: rtl/tug_field.sv
// N-light tug-of-war field: light position, round wins at both ends,
// per-player scores and match-over.
//
//  state | meaning
//  PLAY  | rally in progress, light shown at pos
//  LWIN  | left took the round, waiting for nextRound
//  RWIN  | right took the round, waiting for nextRound
//  OVER  | a score reached MAX_SCORE, only reset leaves
module tug_field
    import tug_pkg::*;
#(
    parameter int N_LIGHTS  = 9,
    parameter int PTS_W     = 3,
    parameter int MAX_SCORE = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    input  logic                nextRound,
    output logic [N_LIGHTS-1:0] lights,
    output logic [PTS_W-1:0]    score_l,
    output logic [PTS_W-1:0]    score_r,
    output logic [1:0]          winner,
    output logic                gameOver
);

    localparam int                POS_W   = $clog2(N_LIGHTS);
    localparam logic [POS_W-1:0]  CENTER  = POS_W'(N_LIGHTS / 2);
    localparam logic [POS_W-1:0]  LAST    = POS_W'(N_LIGHTS - 1);
    localparam logic [PTS_W-1:0]  LAST_PT = PTS_W'(MAX_SCORE - 1);
    localparam logic [N_LIGHTS-1:0] ONE   = N_LIGHTS'(1);

    tug_state_t       r_state;
    tug_state_t       w_next_state;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_next_pos;
    logic [1:0]       r_final;
    logic             w_inc_l;
    logic             w_inc_r;
    logic             w_move_l;
    logic             w_move_r;
    logic [PTS_W-1:0] w_score_l;
    logic [PTS_W-1:0] w_score_r;
    logic             w_atmax_l;
    logic             w_atmax_r;

    assign w_move_l = L & ~R;
    assign w_move_r = R & ~L;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PLAY;
            r_pos   <= CENTER;
            r_final <= WIN_NONE;
        end else begin
            r_state <= w_next_state;
            r_pos   <= w_next_pos;
            if (w_inc_l) begin
                r_final <= WIN_L;
            end else if (w_inc_r) begin
                r_final <= WIN_R;
            end
        end
    end

    // The winning point is the one that brings a score from MAX-1 to MAX.
    always_comb begin
        w_next_state = r_state;
        w_next_pos   = r_pos;
        w_inc_l      = 1'b0;
        w_inc_r      = 1'b0;
        unique case (r_state)
            PLAY: begin
                if (nextRound) begin
                    w_next_pos = CENTER;
                end else if (w_move_r) begin
                    if (r_pos == '0) begin
                        w_inc_r      = 1'b1;
                        w_next_state = (w_score_r == LAST_PT) ? OVER : RWIN;
                    end else begin
                        w_next_pos = r_pos - 1'b1;
                    end
                end else if (w_move_l) begin
                    if (r_pos == LAST) begin
                        w_inc_l      = 1'b1;
                        w_next_state = (w_score_l == LAST_PT) ? OVER : LWIN;
                    end else begin
                        w_next_pos = r_pos + 1'b1;
                    end
                end
            end
            LWIN, RWIN: begin
                if (nextRound) begin
                    w_next_state = PLAY;
                    w_next_pos   = CENTER;
                end
            end
            OVER: begin
                w_next_state = OVER;
            end
            default: begin
                w_next_state = PLAY;
                w_next_pos   = CENTER;
            end
        endcase
    end

    always_comb begin
        lights = '0;
        winner = WIN_NONE;
        unique case (r_state)
            PLAY:    lights = ONE << r_pos;
            LWIN:    winner = WIN_L;
            RWIN:    winner = WIN_R;
            OVER:    winner = r_final;
            default: winner = WIN_NONE;
        endcase
    end

    tug_score #(
        .PTS_W     (PTS_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_score_l (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_l),
        .count (w_score_l),
        .atMax (w_atmax_l)
    );

    tug_score #(
        .PTS_W     (PTS_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_score_r (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_r),
        .count (w_score_r),
        .atMax (w_atmax_r)
    );

    assign score_l  = w_score_l;
    assign score_r  = w_score_r;
    assign gameOver = w_atmax_l | w_atmax_r;

endmodule
